// File: rtl/mouse_click_sequencer.sv
// Avalon-MM click sequencer: queued hold lengths are played out as timed pulses
// on out_port, separated by a programmable gap, with an irq when the queue drains.
module mouse_click_sequencer #(
    parameter int HOLD_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        out_port,
    output logic        busy,
    output logic        irq
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [HOLD_W-1:0] HOLD_ONE = 1;
    localparam logic [AW-1:0]     PTR_ONE  = 1;
    localparam logic [CW-1:0]     CNT_ONE  = 1;
    localparam logic [CW-1:0]     CNT_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

    state_t            state, state_nx;
    logic [HOLD_W-1:0] cnt, cnt_nx;
    logic              out_nx;
    logic [HOLD_W-1:0] gap_reg;
    logic              irq_en, overflow, irq_pending, irq_set;

    logic [HOLD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic [HOLD_W-1:0] head;
    logic              empty, full, we, push_req, push, pop, flush;
    wire               unused = ^writedata[31:HOLD_W];

    assign we       = chipselect & ~write_n;
    assign push_req = we && (address == 2'd0);
    assign flush    = we && (address == 2'd2) && writedata[0];
    assign empty    = (count == '0);
    assign full     = (count == CNT_FULL);
    // Flush wins over a same-cycle push; the dropped push does not count as overflow.
    assign push     = push_req & ~full & ~flush;
    assign head     = mem[rd_ptr];

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        out_nx   = out_port;
        pop      = 1'b0;
        irq_set  = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    cnt_nx   = (head == '0) ? '0 : head - HOLD_ONE;
                    out_nx   = 1'b1;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    out_nx = 1'b0;
                    if (gap_reg == '0) begin
                        state_nx = IDLE;
                        irq_set  = empty;
                    end else begin
                        cnt_nx   = gap_reg - HOLD_ONE;
                        state_nx = GAP;
                    end
                end else begin
                    cnt_nx = cnt - HOLD_ONE;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_nx = IDLE;
                    irq_set  = empty;
                end else begin
                    cnt_nx = cnt - HOLD_ONE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (flush) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            out_nx   = 1'b0;
            pop      = 1'b0;
            irq_set  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            out_port <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            out_port <= out_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= writedata[HOLD_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gap_reg     <= '0;
            irq_en      <= 1'b0;
            overflow    <= 1'b0;
            irq_pending <= 1'b0;
        end else begin
            if (we && address == 2'd1) gap_reg <= writedata[HOLD_W-1:0];
            if (we && address == 2'd3) irq_en <= writedata[0];
            if (push_req && full && !flush)
                overflow <= 1'b1;
            else if (we && address == 2'd2 && writedata[1])
                overflow <= 1'b0;
            if (irq_set)
                irq_pending <= 1'b1;
            else if (we && address == 2'd2 && writedata[2])
                irq_pending <= 1'b0;
        end
    end

    assign busy = (state != IDLE) || !empty;
    assign irq  = irq_pending & irq_en;

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: readdata[CW-1:0]     = count;
            2'd1: readdata[HOLD_W-1:0] = gap_reg;
            2'd2: readdata[4:0]        = {irq_pending, overflow, full, empty, busy};
            default: readdata[0]       = irq_en;
        endcase
    end
endmodule
